// File: rtl/alu_cmd_driver.sv
// Initiator for the 4-bit ALU: accepts a command, drives the ALU, waits a settle interval,
// captures and flag-masks the result, then hands it downstream. Optional sweep mode: ALU_DRV_SWEEP_EN.
module alu_cmd_driver #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_a,
    input  logic [3:0]         cmd_b,
    input  logic [2:0]         cmd_func,
    input  logic               cmd_sweep,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [2:0]         alu_func,
    input  logic [3:0]         alu_s,
    input  logic               alu_eq,
    input  logic               alu_lt,
    input  logic               alu_ovf,
    input  logic               alu_carry,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_s,
    output logic [3:0]         res_flags,
    output logic [2:0]         res_func,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [FUNC_W-1:0] FUNC_LAST   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_cmd_ready;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [FUNC_W-1:0]   r_alu_func;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_s;
    logic [FLAG_W-1:0]   r_res_flags;
    logic [FUNC_W-1:0]   r_res_func;
    logic                r_busy;
    logic [COUNT_W-1:0]  r_op_count;

    logic [DATA_W-1:0]   w_cap_s;
    logic [FLAG_W-1:0]   w_cap_flags;
    logic                w_sweep_more;
    logic [FUNC_W-1:0]   w_start_func;

`ifdef ALU_DRV_SWEEP_EN
    logic r_sweep;
    assign w_sweep_more = r_sweep && (r_alu_func != FUNC_LAST);
    assign w_start_func = cmd_sweep ? FUNC_W'(0) : cmd_func;
`else
    logic w_unused_sweep;
    assign w_unused_sweep = cmd_sweep;
    assign w_sweep_more   = 1'b0;
    assign w_start_func   = cmd_func;
`endif

    // The ALU keeps stale flags between ops, so only flags meaningful for the opcode pass through.
    always_comb begin
        w_cap_s     = alu_s;
        w_cap_flags = '0;
        case (r_alu_func)
            3'b000, 3'b001: w_cap_flags = {alu_carry, alu_ovf, 2'b00};
            3'b110: begin
                w_cap_s     = '0;
                w_cap_flags = {2'b00, alu_lt, 1'b0};
            end
            3'b111: begin
                w_cap_s     = '0;
                w_cap_flags = {3'b000, alu_eq};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_func  <= '0;
            r_res_valid <= 1'b0;
            r_res_s     <= '0;
            r_res_flags <= '0;
            r_res_func  <= '0;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
`ifdef ALU_DRV_SWEEP_EN
            r_sweep     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_alu_a     <= cmd_a;
                        r_alu_b     <= cmd_b;
                        r_alu_func  <= w_start_func;
                        r_cnt       <= SETTLE_LOAD;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETTLE;
`ifdef ALU_DRV_SWEEP_EN
                        r_sweep     <= cmd_sweep;
`endif
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_res_s     <= w_cap_s;
                        r_res_flags <= w_cap_flags;
                        r_res_func  <= r_alu_func;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + COUNT_W'(1);
                        if (w_sweep_more) begin
                            r_alu_func <= r_alu_func + FUNC_W'(1);
                            r_cnt      <= SETTLE_LOAD;
                            r_state    <= S_SETTLE;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_func  = r_alu_func;
    assign res_valid = r_res_valid;
    assign res_s     = r_res_s;
    assign res_flags = r_res_flags;
    assign res_func  = r_res_func;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (settle 1 and 3) each fed by a behavioural ALU whose
// inapplicable flags carry random stale values; results are checked against an integer reference.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_w [2];
    logic       cmd_valid, res_ready, cmd_sweep;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_func;
    logic [3:0] stale;

    logic       cmd_ready_w [2];
    logic [3:0] alu_a_w [2];
    logic [3:0] alu_b_w [2];
    logic [2:0] alu_func_w [2];
    logic [3:0] alu_s_w [2];
    logic       alu_eq_w [2], alu_lt_w [2], alu_ovf_w [2], alu_carry_w [2];
    logic       res_valid_w [2];
    logic [3:0] res_s_w [2];
    logic [3:0] res_flags_w [2];
    logic [2:0] res_func_w [2];
    logic       busy_w [2];
    logic [7:0] op_count_w [2];

    int n_cmp = 0;
    int n_mis = 0;
    int exp_count [2];

    always #5 clk = ~clk;

    // ALU stand-in: real results for the opcode, stale/junk values everywhere else.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] f, input logic [3:0] st);
        logic [4:0] t;
        logic [3:0] s;
        logic c, o, lt, eq;
        s = a ^ st; c = st[3]; o = st[2]; lt = st[1]; eq = st[0];
        case (f)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; s = t[3:0]; c = t[4];
                        o = (a[3] == b[3]) && (s[3] != a[3]); end
            3'd1: begin t = {1'b0, a} + {1'b0, ~b} + 5'd1; s = t[3:0]; c = t[4];
                        o = (a[3] != b[3]) && (s[3] != a[3]); end
            3'd2: s = ~a;
            3'd3: s = a & b;
            3'd4: s = a | b;
            3'd5: s = a ^ b;
            3'd6: lt = (a < b);
            default: eq = (a == b);
        endcase
        return {s, c, o, lt, eq};
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        assign {alu_s_w[i], alu_carry_w[i], alu_ovf_w[i], alu_lt_w[i], alu_eq_w[i]} =
            alu_model(alu_a_w[i], alu_b_w[i], alu_func_w[i], stale);

        alu_cmd_driver #(.SETTLE_CYCLES((i == 0) ? 1 : 3), .COUNT_W(8)) u_dut (
            .clk(clk), .rst(rst_w[i]),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[i]),
            .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func), .cmd_sweep(cmd_sweep),
            .alu_a(alu_a_w[i]), .alu_b(alu_b_w[i]), .alu_func(alu_func_w[i]),
            .alu_s(alu_s_w[i]), .alu_eq(alu_eq_w[i]), .alu_lt(alu_lt_w[i]),
            .alu_ovf(alu_ovf_w[i]), .alu_carry(alu_carry_w[i]),
            .res_valid(res_valid_w[i]), .res_ready(res_ready),
            .res_s(res_s_w[i]), .res_flags(res_flags_w[i]), .res_func(res_func_w[i]),
            .busy(busy_w[i]), .op_count(op_count_w[i])
        );
    end

    // Reference: expected {res_s, res_flags} from the opcode rules in signed/unsigned integers.
    function automatic logic [7:0] expected(input int a, input int b, input int f);
        int sa, sb, v, r;
        int s, flags;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        s = 0; flags = 0;
        case (f)
            0: begin v = a + b; r = sa + sb; s = v % 16;
                     flags = ((v > 15) ? 8 : 0) + ((r > 7 || r < -8) ? 4 : 0); end
            1: begin v = a + (15 - b) + 1; r = sa - sb; s = v % 16;
                     flags = ((v > 15) ? 8 : 0) + ((r > 7 || r < -8) ? 4 : 0); end
            2: s = 15 - a;
            3: s = a & b;
            4: s = a | b;
            5: s = a ^ b;
            6: flags = (a < b) ? 2 : 0;
            default: flags = (a == b) ? 1 : 0;
        endcase
        return {4'(s), 4'(flags)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input int idx);
        check("rst_cmd_ready", 32'(cmd_ready_w[idx]), 1);
        check("rst_res_valid", 32'(res_valid_w[idx]), 0);
        check("rst_busy", 32'(busy_w[idx]), 0);
        check("rst_alu", {alu_a_w[idx], alu_b_w[idx], 1'b0, alu_func_w[idx]}, 0);
        check("rst_res", {res_s_w[idx], res_flags_w[idx], 1'b0, res_func_w[idx]}, 0);
        check("rst_op_count", 32'(op_count_w[idx]), 0);
    endtask

    // One command; hold > 0 keeps res_ready low that many cycles per result and holds cmd_valid.
    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] f, input logic sweep, input int hold);
        int settle, nops, t;
        logic [2:0] fk;
        logic [7:0] e;
        settle = (idx == 0) ? 1 : 3;
        nops = 1;
`ifdef ALU_DRV_SWEEP_EN
        if (sweep) nops = 8;
`endif
        t = 0;
        while (cmd_ready_w[idx] !== 1'b1 && t < 20) begin tick(); t++; end
        check("cmd_ready_wait", 32'(cmd_ready_w[idx]), 1);
        cmd_a = a; cmd_b = b; cmd_func = f; cmd_sweep = sweep; cmd_valid = 1'b1;
        tick();
        if (hold == 0) cmd_valid = 1'b0;
        for (int k = 0; k < nops; k++) begin
            fk = (nops == 8) ? 3'(k) : f;
            e = expected(int'(a), int'(b), int'(fk));
            res_ready = (hold == 0);
            check("alu_drive", {alu_a_w[idx], alu_b_w[idx], 1'b0, alu_func_w[idx]},
                  {a, b, 1'b0, fk});
            check("busy_in_op", {31'd0, busy_w[idx]} + {cmd_ready_w[idx], 1'b0}, 1);
            check("no_early_result", 32'(res_valid_w[idx]), 0);
            repeat (settle - 1) tick();
            check("settle_no_result", 32'(res_valid_w[idx]), 0);
            tick();
            check("res_valid_rise", 32'(res_valid_w[idx]), 1);
            check("res_value", {res_s_w[idx], res_flags_w[idx], 1'b0, res_func_w[idx]},
                  {e, 1'b0, fk});
            for (int h = 0; h < hold; h++) begin
                tick();
                check("res_hold", {res_valid_w[idx], cmd_ready_w[idx], res_s_w[idx],
                      res_flags_w[idx], res_func_w[idx]}, {1'b1, 1'b0, e, fk});
            end
            if (k == nops - 1) cmd_valid = 1'b0;
            res_ready = 1'b1;
            tick();
            exp_count[idx]++;
            check("res_valid_fall", 32'(res_valid_w[idx]), 0);
            check("op_count", 32'(op_count_w[idx]), 32'(exp_count[idx] % 256));
            if (k == nops - 1)
                check("done_idle", {busy_w[idx], cmd_ready_w[idx]}, 2'b01);
            else
                check("sweep_busy", {busy_w[idx], cmd_ready_w[idx]}, 2'b10);
        end
        res_ready = 1'b0;
        cmd_sweep = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_w[0] = 1'b0; rst_w[1] = 1'b0;
        cmd_valid = 1'b0; res_ready = 1'b0; cmd_sweep = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_func = '0; stale = '0;
        exp_count[0] = 0; exp_count[1] = 0;
        repeat (3) tick();
        rst_w[0] = 1'b1;
        tick();
        check_reset_state(0);

        stale = 4'b0011;
        run_op(0, 4'b0111, 4'b0001, 3'b000, 1'b0, 0);
        stale = 4'b0000;
        run_op(0, 4'b1000, 4'b0001, 3'b001, 1'b0, 5);
        stale = 4'b1111;
        run_op(0, 4'b0101, 4'b0000, 3'b010, 1'b0, 0);
        stale = 4'b1111;
        run_op(0, 4'b0100, 4'b0100, 3'b000, 1'b1, 0);
        stale = 4'b1101;
        run_op(0, 4'b0011, 4'b1010, 3'b110, 1'b0, 1);

        for (int n = 0; n < 30; n++) begin
            stale = 4'($urandom);
            run_op(0, 4'($urandom), 4'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 2)));
        end

        rst_w[0] = 1'b0;
        rst_w[1] = 1'b1;
        tick();
        check_reset_state(1);
        cmd_a = 4'b0110; cmd_b = 4'b0011; cmd_func = 3'b000; cmd_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_settle_busy", 32'(busy_w[1]), 1);
        #2 rst_w[1] = 1'b0;
        #1 check_reset_state(1);
        tick();
        rst_w[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("abort_no_result", {res_valid_w[1], op_count_w[1]}, 0);
        end
        res_ready = 1'b0;

        for (int n = 0; n < 6; n++) begin
            stale = 4'($urandom);
            run_op(1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0,
                   int'($urandom_range(0, 2)));
        end
        stale = 4'b1010;
        run_op(1, 4'b0100, 4'b0100, 3'b011, 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the 4-bit ALU interface.
- Accepts one command (operands and opcode) over a valid/ready handshake and drives the ALU's A, B and func_sel.
- Waits a settle interval, then samples the ALU outputs into a result register.
- Masks flags that do not apply to the opcode, since the ALU holds stale flag values between operations.
- Presents the result downstream (board display logic) over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, cycles between driving ALU inputs and sampling outputs; legal range 1..15.
COUNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
cmd_valid  in  1  command offered
cmd_ready  out  1  driver can accept a command
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_func  in  3  opcode (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 lt, 111 eq)
cmd_sweep  in  1  sweep request (used only with the optional feature)
alu_a  out  4  to ALU A
alu_b  out  4  to ALU B
alu_func  out  3  to ALU func_sel
alu_s  in  4  ALU out_s
alu_eq  in  1  ALU out_eq
alu_lt  in  1  ALU out_lt
alu_ovf  in  1  ALU overflow
alu_carry  in  1  ALU carry
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_s  out  4  captured result value
res_flags  out  4  {carry, overflow, lt, eq}, masked per opcode
res_func  out  3  opcode that produced the result
busy  out  1  high in any state other than IDLE
op_count  out  COUNT_W  number of completed result handshakes

Behaviour:
- Reset (rst=0, async): state IDLE. cmd_ready=1, all other outputs 0, including alu_*, res_*, busy and op_count.
- Registers: all outputs are registered. alu_* hold the last driven values until the next accepted command.
- FSM states: IDLE, SETTLE, RESULT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at an edge: latch cmd_a/cmd_b/cmd_func into alu_*, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - Counter decrements each cycle. At the edge where the counter is 0: capture the ALU outputs into res_*, set res_valid=1, go to RESULT.
  - Latency: accept at edge N; res_valid=1 from edge N+SETTLE_CYCLES.
- RESULT:
  - res_valid=1; res_s, res_flags and res_func are stable until the handshake completes.
  - On res_valid&&res_ready: res_valid=0, op_count+1 (wraps modulo 2^COUNT_W), go to IDLE.
  - cmd_ready rises the cycle after the handshake; there is no same-cycle bypass.
- Masking at capture:
  - 000/001: res_s=alu_s; carry and overflow taken from the ALU; lt=eq=0.
  - 010..101: res_s=alu_s; all flags 0.
  - 110: res_s=0; lt=alu_lt; all other flags 0.
  - 111: res_s=0; eq=alu_eq; all other flags 0.
- Boundary conditions:
  - cmd_valid while busy is ignored; the upstream source must hold it.
  - res_ready already high when res_valid rises completes the handshake at the next edge, so res_valid is high for exactly one cycle.
  - rst asserted in any state aborts the operation immediately; no partial result is emitted.
  - cmd_sweep is ignored when the optional feature is compiled out.

Optional Feature:
- Macro: ALU_DRV_SWEEP_EN.
- Defined:
  - A command accepted with cmd_sweep=1 ignores cmd_func and runs opcodes 000 through 111 in order on the latched operands.
  - Each opcode goes SETTLE then RESULT, with its own result handshake.
  - After each handshake except the last, return to SETTLE with alu_func+1.
  - busy=1 and cmd_ready=0 for the whole sweep. Go to IDLE after the 111 handshake. op_count increases by 8.
- Undefined:
  - cmd_sweep is unused; every command is a single operation.

Test Plan:
1. rst=0 for 3 cycles, then release -> cmd_ready=1, res_valid=0, busy=0, alu_a=alu_b=0, op_count=0.
2. SETTLE_CYCLES=1, add A=0111 B=0001 func=000, res_ready=1 -> res_valid high exactly 1 cycle, starting at accept edge +1; res_s=1000, res_flags=0100, op_count=1.
3. sub A=1000 B=0001 func=001, res_ready=0 for 5 cycles, cmd_valid held high -> res_s=0111, res_flags=1100; res_* stable; cmd_ready=0 throughout; completes when res_ready=1.
4. not A=0101 func=010, with ALU flags left high from the previous op -> res_s=1010, res_flags=0000.
5. rst pulsed low during SETTLE with SETTLE_CYCLES=3 -> res_valid never asserts; all outputs 0; op_count=0.
6. ALU_DRV_SWEEP_EN: A=0100 B=0100 cmd_sweep=1, res_ready=1 -> 8 results with res_func 000..111. The 110 result has res_flags=0000; the 111 result has res_flags=0001. op_count=8; busy low only after the last handshake.
